// File: rtl/coin_if.sv
// Coin-slot front-end bundle: raw sensors and lockout in, clean events out.
// Handshake: events are single-cycle pulses qualified by nothing else; there is no ready/backpressure.
interface coin_if;
  logic       Nickel_raw;
  logic       Dime_raw;
  logic       Quarter_raw;
  logic       Cancel_raw;
  logic       Lockout;
  logic       Coin_valid;
  logic [4:0] Coin_value;
  logic       Reject;
  logic       Cancel_p;
  logic       Pending;
  logic [7:0] Dbg_state;

  modport master (
    output Nickel_raw, Dime_raw, Quarter_raw, Cancel_raw, Lockout,
    input  Coin_valid, Coin_value, Reject, Cancel_p, Pending, Dbg_state
  );

  modport slave (
    input  Nickel_raw, Dime_raw, Quarter_raw, Cancel_raw, Lockout,
    output Coin_valid, Coin_value, Reject, Cancel_p, Pending, Dbg_state
  );
endinterface

// File: rtl/coin_input_conditioner.sv
// Synchronizes and debounces the coin/cancel inputs, then arbitrates debounced
// coins into registered single-cycle value pulses (quarter > dime > nickel).
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input logic  Clk,
  input logic  Rst,
  coin_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, PRESSED, REL} ch_state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order: 0 nickel, 1 dime, 2 quarter, 3 cancel.
  logic [3:0]       raw;
  logic [3:0]       sync1, sync2;
  ch_state_t        st_q  [4];
  ch_state_t        st_d  [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       evt;

  logic [2:0] pend_q, pend_d, served;
  logic [4:0] served_value;
  logic       cancel_q;
  logic       coin_valid_q, reject_q, cancel_p_q, pending_q;
  logic [4:0] coin_value_q;

  assign raw = {bus.Cancel_raw, bus.Quarter_raw, bus.Dime_raw, bus.Nickel_raw};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1 <= '0;
      sync2 <= '0;
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // The event fires on the sample that brings the stable count to DEBOUNCE_CYCLES.
  always_comb begin
    evt = '0;
    for (int i = 0; i < 4; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        IDLE: if (sync2[i]) begin
          st_d[i]  = ARM;
          cnt_d[i] = CNT_W'(1);
        end
        ARM: if (!sync2[i]) begin
          st_d[i]  = IDLE;
          cnt_d[i] = '0;
        end else if (cnt_q[i] == LAST) begin
          st_d[i]  = PRESSED;
          cnt_d[i] = '0;
          evt[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        PRESSED: if (!sync2[i]) begin
          st_d[i]  = REL;
          cnt_d[i] = CNT_W'(1);
        end
        REL: if (sync2[i]) begin
          st_d[i]  = PRESSED;
          cnt_d[i] = '0;
        end else if (cnt_q[i] == LAST) begin
          st_d[i]  = IDLE;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        default: begin
          st_d[i]  = IDLE;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  always_comb begin
    served = 3'b000;
    if (pend_q[2])      served = 3'b100;
    else if (pend_q[1]) served = 3'b010;
    else if (pend_q[0]) served = 3'b001;
    served_value = served[2] ? 5'd25 : served[1] ? 5'd10 : served[0] ? 5'd5 : 5'd0;
    pend_d = (pend_q & ~served) | evt[2:0];
  end

  // Cancel takes one extra flop so it lines up with a coin debounced on the same cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pend_q       <= '0;
      cancel_q     <= 1'b0;
      coin_valid_q <= 1'b0;
      coin_value_q <= '0;
      reject_q     <= 1'b0;
      cancel_p_q   <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      cancel_q     <= evt[3];
      coin_valid_q <= (|served) & ~bus.Lockout;
      coin_value_q <= bus.Lockout ? 5'd0 : served_value;
      reject_q     <= (|served) & bus.Lockout;
      cancel_p_q   <= cancel_q;
      pending_q    <= |pend_d;
    end
  end

  assign bus.Coin_valid = coin_valid_q;
  assign bus.Coin_value = coin_value_q;
  assign bus.Reject     = reject_q;
  assign bus.Cancel_p   = cancel_p_q;
  assign bus.Pending    = pending_q;
  assign bus.Dbg_state  = {st_q[3], st_q[2], st_q[1], st_q[0]};

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: a vector table plus hand sequences, with
// every output pulse matched against an expected-event queue (cycle included).
module tb_coin_input_conditioner;

  localparam int D = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  coin_if bus ();

  coin_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Record: {cycle[15:0], valid, value[4:0], reject, cancel}
  logic [23:0] exp_q[$];

  typedef struct {
    logic [3:0] mask;  // {cancel, quarter, dime, nickel}
    logic       lock;
    int         hold;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [4:0] coin_val(input int ch);
    return (ch == 2) ? 5'd25 : (ch == 1) ? 5'd10 : 5'd5;
  endfunction

  task automatic push_model(input logic [3:0] mask, input logic lock, input int hold, input int base);
    int n = 0;
    if (hold < D) return;
    for (int ch = 2; ch >= 0; ch--) begin
      if (mask[ch]) begin
        exp_q.push_back({16'(base + n), ~lock, lock ? 5'd0 : coin_val(ch), lock,
                         (n == 0) ? mask[3] : 1'b0});
        n++;
      end
    end
    if (mask[3] && n == 0) exp_q.push_back({16'(base), 1'b0, 5'd0, 1'b0, 1'b1});
  endtask

  task automatic drive_raw(input logic [3:0] m);
    bus.Nickel_raw  = m[0];
    bus.Dime_raw    = m[1];
    bus.Quarter_raw = m[2];
    bus.Cancel_raw  = m[3];
  endtask

  task automatic run_vec(input int idx);
    int base;
    @(negedge Clk);
    drive_raw(vecs[idx].mask);
    bus.Lockout = vecs[idx].lock;
    base = cyc + D + 3;
    push_model(vecs[idx].mask, vecs[idx].lock, vecs[idx].hold, base);
    repeat (vecs[idx].hold) @(negedge Clk);
    drive_raw(4'b0000);
    repeat (2 * D + 8) @(negedge Clk);
    bus.Lockout = 1'b0;
    repeat (4) @(negedge Clk);
    check($sformatf("vec%0d_drain", idx), exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Output monitor: any pulse must be the next expected event, at the expected cycle.
  always @(negedge Clk) begin
    logic [23:0] act, e;
    if (bus.Coin_valid || bus.Reject || bus.Cancel_p) begin
      act = {16'(cyc), bus.Coin_valid, bus.Coin_value, bus.Reject, bus.Cancel_p};
      check("valid_reject_exclusive", {31'd0, bus.Coin_valid & bus.Reject}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event got %h expected none", act);
      end else begin
        e = exp_q.pop_front();
        check("event", {8'd0, act}, {8'd0, e});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    drive_raw(4'b0000);
    bus.Lockout = 1'b0;

    repeat (3) @(negedge Clk);
    check("reset_outputs", {23'd0, bus.Coin_valid, bus.Coin_value, bus.Reject, bus.Cancel_p, bus.Pending}, 0);
    check("reset_state", {24'd0, bus.Dbg_state}, 0);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);

    vecs[0] = '{4'b0010, 1'b0, 20};      // dime held long: one pulse only
    vecs[1] = '{4'b0001, 1'b0, D - 1};   // one sample short: glitch
    vecs[2] = '{4'b0001, 1'b0, D};       // exactly enough samples
    vecs[3] = '{4'b0111, 1'b0, 10};      // 25, 10, 5 back to back
    vecs[4] = '{4'b0100, 1'b1, 8};       // quarter under lockout
    vecs[5] = '{4'b0100, 1'b0, 8};       // same quarter once unlocked
    vecs[6] = '{4'b1010, 1'b0, 8};       // cancel + dime same cycle
    vecs[7] = '{4'b1000, 1'b1, 8};       // cancel ignores lockout
    vecs[8] = '{4'b1111, 1'b1, 9};       // three rejects plus cancel
    vecs[9] = '{4'b0011, 1'b0, D - 1};
    for (int i = 10; i < 16; i++) begin
      vecs[i].mask = 4'($urandom_range(1, 15));
      vecs[i].lock = 1'($urandom_range(0, 1));
      vecs[i].hold = $urandom_range(D - 1, 10);
    end
    for (int i = 0; i < 16; i++) run_vec(i);

    // Bouncing nickel never qualifies and never marks anything pending.
    for (int p = 0; p < 3; p++) begin
      @(negedge Clk);
      bus.Nickel_raw = 1'b1;
      repeat (3) begin
        @(negedge Clk);
        check("bounce_pending", {31'd0, bus.Pending}, 0);
      end
      bus.Nickel_raw = 1'b0;
      @(negedge Clk);
      check("bounce_pending", {31'd0, bus.Pending}, 0);
    end
    repeat (2 * D + 4) begin
      @(negedge Clk);
      check("bounce_pending_tail", {31'd0, bus.Pending}, 0);
    end

    // Pending stays up through the first two of three simultaneous coins.
    @(negedge Clk);
    drive_raw(4'b0111);
    base = cyc + D + 3;
    push_model(4'b0111, 1'b0, 20, base);
    repeat (D + 3) @(negedge Clk);
    check("pending_first", {31'd0, bus.Pending}, 1);
    @(negedge Clk);
    check("pending_second", {31'd0, bus.Pending}, 1);
    @(negedge Clk);
    check("pending_third", {31'd0, bus.Pending}, 0);
    drive_raw(4'b0000);
    repeat (2 * D + 8) @(negedge Clk);
    check("pending_drain", exp_q.size(), 0);
    exp_q.delete();

    // Reset two cycles before a nickel pulse is due discards it.
    @(negedge Clk);
    bus.Nickel_raw = 1'b1;
    repeat (D + 1) @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("midreset_outputs", {23'd0, bus.Coin_valid, bus.Coin_value, bus.Reject, bus.Cancel_p, bus.Pending}, 0);
    bus.Nickel_raw = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      check("midreset_hold", {23'd0, bus.Coin_valid, bus.Coin_value, bus.Reject, bus.Cancel_p, bus.Pending}, 0);
    end
    Rst = 1'b1;
    repeat (15) begin
      @(negedge Clk);
      check("postreset_pending", {31'd0, bus.Pending}, 0);
    end
    check("postreset_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
Front-end stage of the soda machine. It takes raw, asynchronous, bouncing coin-slot and cancel-button signals and produces clean, registered, single-cycle event pulses plus an encoded coin value. These outputs drive the next-state logic whose result is captured by the falling-edge state register.
All outputs are registered on the rising edge of Clk, which gives the falling-edge consumer a half-cycle of setup.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a level change (legal range 2..31)
CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
Clk  input  1  system clock; all internal registers are rising-edge
Rst  input  1  reset, asynchronous, active-low
Nickel_raw  input  1  raw nickel-slot sensor, asynchronous, active-high
Dime_raw  input  1  raw dime-slot sensor, asynchronous, active-high
Quarter_raw  input  1  raw quarter-slot sensor, asynchronous, active-high
Cancel_raw  input  1  raw cancel button, asynchronous, active-high
Lockout  input  1  synchronous; high while a vend/refund is in progress
Coin_valid  output  1  one-cycle pulse: a coin was accepted
Coin_value  output  5  cents of the accepted coin (5, 10 or 25); 0 when Coin_valid=0
Reject  output  1  one-cycle pulse: a coin arrived (or was due for emission) during Lockout
Cancel_p  output  1  one-cycle pulse on a debounced cancel press
Pending  output  1  high while one or more debounced coins await emission

Behaviour:
Reset (Rst=0, asynchronous):
- All synchronizers, counters, channel states and pending bits are cleared.
- Coin_valid, Coin_value, Reject, Cancel_p and Pending are 0.
- Reset asserted mid-debounce or with coins pending discards everything; nothing is emitted after release.

Synchronization:
- Each raw input passes through a 2-flop synchronizer before any other logic sees it.

Per-channel FSM (four identical instances):
- IDLE: sync=1 -> ARM with cnt=1.
- ARM: sync=1 -> cnt++. When cnt reaches DEBOUNCE_CYCLES -> PRESSED and the channel raises its event. sync=0 -> IDLE, cnt=0 (glitch rejected).
- PRESSED: sync=0 -> REL with cnt=1.
- REL: sync=0 -> cnt++. When cnt reaches DEBOUNCE_CYCLES -> IDLE. sync=1 -> PRESSED, cnt=0.
- Exactly one event per press; holding an input high never retriggers.

Latency:
- With a raw input held stable from rising edge k, the output pulse is high for exactly the cycle following edge k+DEBOUNCE_CYCLES+2.

Cancel path:
- Cancel event -> Cancel_p in that same output cycle.
- Cancel_p is independent of Lockout and of coin arbitration.

Coin events:
- A coin event sets that channel's pending bit.
- Each cycle, at most one pending bit is served, by priority quarter > dime > nickel.
- The served bit clears in the same cycle.
- Lockout=0 at service: Coin_valid=1, Coin_value = 25/10/5.
- Lockout=1 at service: Reject=1, Coin_valid=0, Coin_value=0.
- Coin_valid and Reject are never high together.

Simultaneous events and counts:
- Coins debounced in the same cycle emerge on consecutive cycles in priority order. Example: all three together -> 25, then 10, then 5.
- A new event on a channel whose pending bit is still set is not counted twice. This is unreachable in practice because re-press requires a full release debounce.

Pending output:
- Pending = OR of the pending bits, registered.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4.)
1. Reset, then hold Dime_raw high for 20 cycles -> exactly one Coin_valid pulse, Coin_value=10, on the 7th cycle after the first sampling edge. No further pulses while the input stays held.
2. Nickel_raw pulses high for 3 cycles, three times, with 2-cycle gaps -> no Coin_valid, no Reject, Pending stays 0.
3. Quarter, Dime and Nickel raised on the same edge and held -> Coin_valid on 3 consecutive cycles with Coin_value 25, 10, 5. Pending is high for the first 2 of those cycles and drops to 0 on the third.
4. Lockout=1, then insert a quarter -> Reject pulses once, Coin_valid stays 0. Then Lockout=0, release, and re-insert -> Coin_valid with value 25.
5. Cancel_raw and Dime_raw raised together -> Cancel_p and Coin_valid (value 10) are high in the same cycle.
6. Insert a nickel and assert Rst low 2 cycles before the pulse is due; release Rst -> no Coin_valid ever appears, all outputs are 0 during reset, and Pending stays 0.
